// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SLC-3 on-chip SRAM responder.
//   state_t      : responder FSM states (INIT = loader running, SERVE = normal)
//   INIT_LEN_MAX : number of entries in the preload image table
//   IMAGE        : LC-3 program image copied into the low words at reset
//   image_word() : indexed lookup into IMAGE
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int INIT_LEN_MAX = 32;
  localparam int IMAGE_IDX_W  = $clog2(INIT_LEN_MAX);

  // Small LC-3 test program: sums 5+4+3+2+1 into R1, stores it at x0008 and
  // then spins on a branch-to-self.
  localparam logic [15:0] IMAGE [INIT_LEN_MAX] = '{
    16'h5020,  // x00 AND R0,R0,#0
    16'h1025,  // x01 ADD R0,R0,#5
    16'h5260,  // x02 AND R1,R1,#0
    16'h1240,  // x03 ADD R1,R1,R0
    16'h103F,  // x04 ADD R0,R0,#-1
    16'h03FD,  // x05 BRp x03
    16'h3201,  // x06 ST  R1,x08
    16'h0FFF,  // x07 BRnzp x07
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  function automatic logic [15:0] image_word(input logic [IMAGE_IDX_W-1:0] idx);
    return IMAGE[idx];
  endfunction

endpackage

// File: rtl/mem_bus_driver.sv
// mem_bus_driver: per-byte-lane tri-state driver onto the shared SRAM bus.
//   data    : word to present on the bus
//   lane_en : [1] drives bus[15:8], [0] drives bus[7:0]; a disabled lane floats
//   bus     : shared bidirectional data bus
module mem_bus_driver (
  input  logic [15:0] data,
  input  logic [1:0]  lane_en,
  inout  wire  [15:0] bus
);

  assign bus[15:8] = lane_en[1] ? data[15:8] : 8'hzz;
  assign bus[7:0]  = lane_en[0] ? data[7:0]  : 8'hzz;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: byte-lane SRAM model for the SLC-3 external memory port.
// After reset a loader clears the whole array and preloads the program image,
// then the block answers CPU accesses with one-cycle registered read latency.
//   Clk       : system clock, all state changes on the rising edge
//   Reset     : asynchronous active-low reset; restarts the loader
//   A         : CPU word address; only A[ADDR_W-1:0] is decoded (aliases wrap)
//   CE_out    : active-low chip enable
//   OE_out    : active-low output enable
//   WE_out    : active-low write enable (wins over OE_out)
//   UB_out    : active-low upper byte lane enable
//   LB_out    : active-low lower byte lane enable
//   Mem_bus   : shared 16-bit data bus, each lane driven or Z independently
//   Init_done : high once the loader has written every word
// ADDR_W must be at least $clog2(INIT_LEN_MAX) and INIT_LEN at most
// INIT_LEN_MAX (and at most 2^ADDR_W).
import sram_pkg::*;

module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int INIT_LEN = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] A,
  input  logic        CE_out,
  input  logic        OE_out,
  input  logic        WE_out,
  input  logic        UB_out,
  input  logic        LB_out,
  inout  wire  [15:0] Mem_bus,
  output logic        Init_done
);

  localparam int               DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  INIT_LEN_C = (ADDR_W + 1)'(INIT_LEN);

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic [15:0]         rdata;
  logic [15:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   addr;
  logic                serving;
  logic                cpu_write;
  logic                cpu_read;
  logic [15:0]         loader_word;
  logic                wr_en;
  logic [1:0]          wr_be;
  logic [ADDR_W-1:0]   wr_addr;
  logic [15:0]         wr_data;
  logic [1:0]          lane_en;
  logic                unused_addr_hi;

  // Upper address bits are deliberately ignored so accesses alias.
  assign addr           = A[ADDR_W-1:0];
  assign unused_addr_hi = ^A[19:ADDR_W];

  assign serving   = (state == SERVE);
  assign cpu_write = !CE_out && !WE_out;
  assign cpu_read  = !CE_out &&  WE_out && !OE_out;

  assign loader_word = ({1'b0, init_cnt} < INIT_LEN_C)
                     ? image_word(init_cnt[IMAGE_IDX_W-1:0]) : 16'h0000;

  // Single write port shared by the loader (INIT) and the CPU (SERVE).
  // NOTE: every output gets a default before the if-chain so no path leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    wr_en   = 1'b0;
    wr_be   = 2'b00;
    wr_addr = addr;
    wr_data = Mem_bus;
    if (!serving) begin
      wr_en   = 1'b1;
      wr_be   = 2'b11;
      wr_addr = init_cnt;
      wr_data = loader_word;
    end else if (cpu_write) begin
      wr_en = 1'b1;
      wr_be = {!UB_out, !LB_out};
    end
  end

  // Loader / mode FSM with registered Init_done.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      Init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state     <= SERVE;
            Init_done <= 1'b1;
          end
        end
        SERVE: ;
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: the array itself has no reset; the loader rewrites every word after
  // reset, and leaving the reset off keeps it mappable onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
      if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    end
  end

  // Registered read data; reads and writes are mutually exclusive because
  // WE low turns any access into a write.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdata <= 16'h0000;
    end else if (serving && cpu_read) begin
      rdata <= mem[addr];
    end
  end

  // Drive decode follows the live strobes so the bus releases as soon as the
  // CPU deasserts OE/CE or raises WE, and immediately on reset.
  assign lane_en[1] = serving && !CE_out && !OE_out && WE_out && !UB_out;
  assign lane_en[0] = serving && !CE_out && !OE_out && WE_out && !LB_out;

  mem_bus_driver u_mem_bus_driver (
    .data    (rdata),
    .lane_en (lane_en),
    .bus     (Mem_bus)
  );

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bench for sram_responder. Stimulus pushes the
// expected bus / Init_done value for the current cycle into a scoreboard
// queue; a monitor on the falling edge pops and compares. The bus is pulled
// up here, so a released bus (or released lane) reads as all ones.
module tb_sram_responder;

  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] A;
  logic        CE_out, OE_out, WE_out, UB_out, LB_out;
  tri1  [15:0] Mem_bus;
  logic        Init_done;

  logic        tb_en;
  logic [15:0] tb_data;

  assign Mem_bus = tb_en ? tb_data : 16'hzzzz;

  sram_responder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .A         (A),
    .CE_out    (CE_out),
    .OE_out    (OE_out),
    .WE_out    (WE_out),
    .UB_out    (UB_out),
    .LB_out    (LB_out),
    .Mem_bus   (Mem_bus),
    .Init_done (Init_done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_bus;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Monitor: compares every expectation tagged with the current cycle.
  always @(negedge Clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (e.is_bus) begin
        if (Mem_bus !== e.exp) begin
          errors++;
          $display("FAIL %s: cycle %0d Mem_bus got %h expected %h", e.name, cyc, Mem_bus, e.exp);
        end
      end else if (Init_done !== e.exp[0]) begin
        errors++;
        $display("FAIL %s: cycle %0d Init_done got %b expected %b", e.name, cyc, Init_done, e.exp[0]);
      end
    end
    if (stim_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_bus(input string name, input logic [15:0] v);
    sb.push_back('{cyc: cyc, is_bus: 1'b1, exp: v, name: name});
  endtask

  task automatic expect_done(input string name, input logic v);
    sb.push_back('{cyc: cyc, is_bus: 1'b0, exp: {15'h0, v}, name: name});
  endtask

  // Apply one cycle's worth of inputs just after the rising edge.
  task automatic drive(input logic [19:0] a, input logic ce, input logic oe,
                       input logic we, input logic ub, input logic lb,
                       input logic ten, input logic [15:0] tdata);
    @(posedge Clk);
    #1;
    A = a; CE_out = ce; OE_out = oe; WE_out = we; UB_out = ub; LB_out = lb;
    tb_en = ten; tb_data = tdata;
  endtask

  task automatic rd(input logic [19:0] a, input logic ub, input logic lb,
                    input string name, input logic [15:0] exp_bus);
    drive(a, 1'b0, 1'b0, 1'b1, ub, lb, 1'b0, 16'h0000);
    expect_bus(name, exp_bus);
  endtask

  task automatic wr(input logic [19:0] a, input logic oe, input logic ub,
                    input logic lb, input logic [15:0] d, input string name);
    drive(a, 1'b0, oe, 1'b0, ub, lb, 1'b1, d);
    expect_bus(name, d);
  endtask

  // Reset is already low on entry: hold three cycles with read strobes active,
  // release, then follow the loader edge by edge.
  task automatic run_init();
    for (int k = 0; k < 3; k++) begin
      rd(20'h00040, 1'b0, 1'b0, "rst_bus_z", BUS_Z);
      expect_done("rst_done_low", 1'b0);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int j = 1; j <= 1024; j++) begin
      // The final loader edge switches to SERVE with rdata still at reset 0.
      rd(20'h00040, 1'b0, 1'b0, (j < 1024) ? "init_bus_z" : "init_end_bus",
         (j < 1024) ? BUS_Z : 16'h0000);
      expect_done((j < 1024) ? "init_done_low" : "init_done_high", j == 1024);
    end
  endtask

  initial begin
    Reset = 1'b0;
    A = '0; CE_out = 1'b1; OE_out = 1'b1; WE_out = 1'b1; UB_out = 1'b1; LB_out = 1'b1;
    tb_en = 1'b0; tb_data = 16'h0000;

    run_init();

    // Streaming reads: data lags the address by one cycle.
    rd(20'h00000, 1'b0, 1'b0, "rd_40_zero",  16'h0000);
    rd(20'h00001, 1'b0, 1'b0, "rd_0",        16'h5020);
    rd(20'h00001, 1'b0, 1'b0, "rd_1",        16'h1025);
    // Full write then read-back.
    wr(20'h00020, 1'b1, 1'b0, 1'b0, 16'h1234, "wr_1234_bus");
    rd(20'h00020, 1'b0, 1'b0, "rd_lag_1025", 16'h1025);
    rd(20'h00001, 1'b0, 1'b0, "rd_20_1234",  16'h1234);
    // Lower-lane-only write with OE also low: responder must stay off the bus.
    wr(20'h00020, 1'b0, 1'b1, 1'b0, 16'hABCD, "wr_lane_bus");
    rd(20'h00020, 1'b0, 1'b0, "rd_hold_1025", 16'h1025);
    rd(20'h00420, 1'b0, 1'b0, "rd_20_12cd",  16'h12CD);
    rd(20'h00000, 1'b0, 1'b1, "rd_alias_ub", 16'h12FF);
    rd(20'h00020, 1'b1, 1'b0, "rd_lb_only",  16'hFF20);
    // CE=OE=WE=0: write wins, bus carries only the bench's data.
    wr(20'h00021, 1'b0, 1'b0, 1'b0, 16'h5555, "prio_bus");
    rd(20'h00021, 1'b0, 1'b0, "rd_no_load",  16'h12CD);
    rd(20'h00020, 1'b0, 1'b0, "rd_21_5555",  16'h5555);
    rd(20'h00000, 1'b0, 1'b0, "rd_20_again", 16'h12CD);
    rd(20'h00001, 1'b0, 1'b0, "rd_0_again",  16'h5020);
    // Reset in the middle of the stream, same cycle as new read strobes.
    drive(20'h00002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    Reset = 1'b0;
    expect_bus("rst_async_z", BUS_Z);
    expect_done("rst_async_done", 1'b0);

    run_init();

    rd(20'h00020, 1'b0, 1'b0, "rd_40_again", 16'h0000);
    rd(20'h00021, 1'b0, 1'b0, "reinit_20",   16'h0000);
    rd(20'h00000, 1'b0, 1'b0, "reinit_21",   16'h0000);
    drive(20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_bus("ce_high_z", BUS_Z);

    @(posedge Clk);
    #1;
    stim_done = 1'b1;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the SLC-3 external SRAM interface. Sits on the far side of the CPU's memory port (A, Mem_bus and the active-low CE/OE/WE/UB/LB strobes) and behaves as a byte-lane SRAM with one-cycle registered read latency. On reset it runs a loader that clears the array and preloads a program image, so the CPU can run on-chip without external SRAM.

## Interface
- ADDR_W, default 10: word-address width; depth is 2^ADDR_W 16-bit words.
- INIT_LEN, default 32: number of leading words preloaded from the package image table; must be ≤ 2^ADDR_W.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low. Asserting it forces the INIT state with the counter at 0 and releases Mem_bus immediately.
- A  in  20  word address from the CPU; only A[ADDR_W-1:0] is used.
- CE_out, OE_out, WE_out  in  1 each  active-low chip enable, output enable and write enable from the CPU.
- UB_out, LB_out  in  1 each  active-low upper-byte and lower-byte lane enables.
- Mem_bus  inout  16  shared data bus; each byte lane is driven or Z independently.
- Init_done  out  1  high once preload is complete.
  - Reset value: 0.

## Operation
- States:
  - INIT: loader. A counter i runs from 0 to 2^ADDR_W−1 and writes IMAGE[i] when i<INIT_LEN, else 0x0000.
    - The last write moves the FSM to SERVE and sets Init_done=1.
    - All CPU strobes are ignored and Mem_bus is Z.
  - SERVE: normal operation; the FSM leaves it only via Reset.
- Access decode in SERVE, with strobes sampled at the rising edge:
  - write = !CE && !WE
  - read = !CE && WE && !OE
  - WE takes priority over OE.
- Write: at the edge, mem[A] is updated per lane.
  - !UB writes [15:8] from Mem_bus.
  - !LB writes [7:0] from Mem_bus.
  - A disabled lane keeps its old value.
- Read: each edge with read true loads rdata ← mem[A].
- Bus drive (combinational on the current strobes): a lane is driven with rdata only while CE, OE and its lane enable are low, WE is high, and the state is SERVE.
  - Every other case is Z, including during writes, so there is no contention with the CPU driving the bus.
- Address aliasing: A[19:ADDR_W] is ignored, so accesses wrap modulo the depth.

## Timing
- Read latency is 1 cycle: rdata reflects the address sampled at edge k from edge k on.
- Back-to-back reads stream one word per cycle, with the data lagging the address by one cycle.
- Write commits at the sampling edge. A read of the same address at the next edge returns the new data, with no bypass needed.
- Init takes exactly 2^ADDR_W cycles after Reset deasserts; Init_done rises on the edge that performs the final write.
- Reset mid-access:
  - Mem_bus goes Z asynchronously.
  - Any in-flight write that is not yet at an edge is lost.
  - The array is fully reinitialized.
- Reset values: Init_done=0, rdata=0x0000, state=INIT, counter=0, Mem_bus Z.

## Structure
- Package sram_pkg holds:
  - the state enum {INIT, SERVE}
  - constant INIT_LEN_MAX
  - IMAGE as a 16-bit constant array (LC-3 test program; IMAGE[0]=0x5020, IMAGE[1]=0x1025)
- One sub-module, mem_bus_driver: a per-lane tri-state driver taking rdata and two lane-enable bits, connected to Mem_bus.
- The array is inferred as single-port RAM with byte-enable writes. The loader shares the write port through a state-based mux.

## Test plan
- Hold Reset low 3 cycles, then release:
  - Init_done stays 0 for exactly 1024 cycles, then goes 1.
  - Mem_bus is Z throughout, even with CE=OE=0.
- After init, read A=0x00000 then A=0x00001 with UB=LB=0: Mem_bus shows 0x5020, then 0x1025, each one cycle after its address. A=0x00040 reads 0x0000.
- Write 0x1234 to A=0x00020 with UB=LB=0, then read it: Mem_bus reads 0x1234 and is Z during the write cycle.
- Byte lanes:
  - Write 0xABCD to A=0x00020 with UB=1, LB=0; a full read returns 0x12CD.
  - A read with UB=0, LB=1 gives Mem_bus[15:8]=0x12 and [7:0]=Z.
- Aliasing and priority:
  - Reading A=0x00420 returns 0x12CD.
  - With CE=OE=WE=0, 0x5555 is written and the responder never drives the bus.
- Assert Reset during a streaming read: Mem_bus goes Z in the same cycle, Init_done=0, and after re-init A=0x00020 reads 0x0000.
